// File: rtl/gcd_binary_sync_pkg.sv
// -----------------------------------------------------------------------------
// gcd_binary_sync_pkg
// Shared definitions for the binary (Stein) GCD call-protocol core:
//   - gcd_state_t  : FSM encoding (IDLE=0, SCALE=1, ODD=2, DONE=3)
//   - STEPS_W      : width of the optional step counter output
//   - gcd_latency_bound(n) : worst-case accept-to-result latency (4n+2),
//                            used by benches to bound their waits
// No ports (package).
// -----------------------------------------------------------------------------
package gcd_binary_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        ODD   = 2'd2,
        DONE  = 2'd3
    } gcd_state_t;

    localparam int STEPS_W = 16;

    function automatic int gcd_latency_bound(input int n);
        return 4 * n + 2;
    endfunction

endpackage

// File: rtl/gcd_binary_step.sv
// -----------------------------------------------------------------------------
// gcd_binary_step
// Purely combinational single step of the binary GCD algorithm. Given the
// current FSM state and operand registers it returns their next values.
//   i_state  : current FSM state (only SCALE and ODD change anything)
//   i_a, i_b : current operands (N bits, unsigned)
//   i_k      : common power-of-two count so far (KW bits)
//   o_a, o_b : next operands
//   o_k      : next power-of-two count
//   o_done   : ODD step found a==b, result is ready
//   o_result : a << k, the gcd when o_done is set
// -----------------------------------------------------------------------------
module gcd_binary_step
    import gcd_binary_sync_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = $clog2(N) + 1
) (
    input  gcd_state_t      i_state,
    input  logic [N-1:0]    i_a,
    input  logic [N-1:0]    i_b,
    input  logic [KW-1:0]   i_k,
    output logic [N-1:0]    o_a,
    output logic [N-1:0]    o_b,
    output logic [KW-1:0]   o_k,
    output logic            o_done,
    output logic [N-1:0]    o_result
);

    // a<<k never exceeds min(in0,in1), so truncation to N bits is lossless.
    assign o_result = i_a << i_k;

    always_comb begin
        o_a    = i_a;
        o_b    = i_b;
        o_k    = i_k;
        o_done = 1'b0;
        case (i_state)
            SCALE: begin
                // Strip common factors of two; leaving SCALE is decided by
                // the wrapper and changes nothing here.
                if (!i_a[0] && !i_b[0]) begin
                    o_a = i_a >> 1;
                    o_b = i_b >> 1;
                    o_k = i_k + 1'b1;
                end
            end
            ODD: begin
                // One action per cycle, in priority order. Both operands are
                // odd before any subtraction, so the difference is even and
                // the larger-minus-smaller form never wraps.
                if (!i_a[0]) begin
                    o_a = i_a >> 1;
                end else if (!i_b[0]) begin
                    o_b = i_b >> 1;
                end else if (i_a == i_b) begin
                    o_done = 1'b1;
                end else if (i_a > i_b) begin
                    o_a = i_a - i_b;
                end else begin
                    o_b = i_b - i_a;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_binary_sync.sv
// -----------------------------------------------------------------------------
// gcd_binary_sync
// Callee side of the synchronous valid/ready call protocol computing
// gcd(in0, in1) with the binary (Stein) algorithm, one step per clock.
// Ports:
//   clk        : clock, all state on rising edge
//   nrst       : asynchronous active-low reset
//   in_valid   : caller offers operands
//   in_ready   : block accepts operands this cycle (combinational)
//   in0, in1   : unsigned operands, N bits
//   out_valid  : out0 holds a finished result
//   out_ready  : caller accepts the result
//   out0       : unsigned gcd result, N bits
//   steps      : (only with GCD_BINARY_STEPCOUNT_EN defined) 16-bit count of
//                cycles from the accept edge to DONE entry, saturating
// Optional feature macro: GCD_BINARY_STEPCOUNT_EN
// -----------------------------------------------------------------------------
module gcd_binary_sync
    import gcd_binary_sync_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in0,
    input  logic [N-1:0]    in1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out0
`ifdef GCD_BINARY_STEPCOUNT_EN
    ,
    output logic [STEPS_W-1:0] steps
`endif
);

    gcd_state_t     r_state;
    gcd_state_t     w_state_nxt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [KW-1:0]  r_k;
    logic [N-1:0]   r_out0;
    logic           r_out_valid;

    logic [N-1:0]   w_a_nxt;
    logic [N-1:0]   w_b_nxt;
    logic [KW-1:0]  w_k_nxt;
    logic           w_done;
    logic [N-1:0]   w_result;
    logic           w_accept;
    logic           w_zero_op;
    logic           w_busy;

    gcd_binary_step #(
        .N  (N),
        .KW (KW)
    ) u_step (
        .i_state  (r_state),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .o_a      (w_a_nxt),
        .o_b      (w_b_nxt),
        .o_k      (w_k_nxt),
        .o_done   (w_done),
        .o_result (w_result)
    );

    // Ready in DONE while the result is being taken allows back-to-back
    // calls; nrst gates it so nothing looks ready during reset.
    assign in_ready  = nrst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign w_zero_op = (in0 == '0) | (in1 == '0);
    assign w_busy    = (r_state == SCALE) | (r_state == ODD);

    assign out_valid = r_out_valid;
    assign out0      = r_out0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_op ? DONE : SCALE;
                end
            end
            SCALE: begin
                if (r_a[0] | r_b[0]) begin
                    w_state_nxt = ODD;
                end
            end
            ODD: begin
                if (w_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nxt = w_zero_op ? DONE : SCALE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_out0      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_a <= in0;
                r_b <= in1;
                r_k <= '0;
                // A zero operand short-circuits: gcd(x,0)=x, gcd(0,0)=0.
                if (w_zero_op) begin
                    r_out0 <= in0 | in1;
                end
            end else if (w_busy) begin
                r_a <= w_a_nxt;
                r_b <= w_b_nxt;
                r_k <= w_k_nxt;
                if (w_done) begin
                    r_out0 <= w_result;
                end
            end
        end
    end

`ifdef GCD_BINARY_STEPCOUNT_EN
    logic [STEPS_W-1:0] r_steps;

    // Counts every SCALE/ODD cycle, including the one whose edge enters
    // DONE, so a zero-operand call reports 0. Frozen in DONE and IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_steps <= '0;
        end else if (w_accept) begin
            r_steps <= '0;
        end else if (w_busy && (r_steps != {STEPS_W{1'b1}})) begin
            r_steps <= r_steps + 1'b1;
        end
    end

    assign steps = r_steps;
`endif

endmodule

// File: tb/tb_gcd_binary_sync.sv
module tb_gcd_binary_sync;
    import gcd_binary_sync_pkg::*;

    localparam int N     = 8;
    localparam int BOUND = gcd_latency_bound(N);

    logic           clk = 1'b0;
    logic           nrst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in0;
    logic [N-1:0]   in1;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out0;
`ifdef GCD_BINARY_STEPCOUNT_EN
    logic [15:0]    steps;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] sb_q[$];

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    gcd_binary_sync #(.N(N)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0)
`ifdef GCD_BINARY_STEPCOUNT_EN
        ,
        .steps     (steps)
`endif
    );

    // Euclid reference, independent of the binary algorithm in the DUT.
    function automatic logic [N-1:0] gcd_ref(input logic [N-1:0] x_in, input logic [N-1:0] y_in);
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] t;
        x = x_in;
        y = y_in;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Scoreboard: expected gcd pushed on every accept, popped on every
    // result handshake. Both are sampled at negedge, before the edge that
    // performs the transfer.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (nrst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("sb_unexpected_result");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_out0", {24'd0, out0}, {24'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(gcd_ref(in0, in1));
            end
        end
    end

    // Offer one call, wait for its accept and for out_valid. lat counts the
    // accept edge as 1, so a zero-operand call yields lat=1.
    task automatic run_call(input logic [N-1:0] a, input logic [N-1:0] b,
                            output int lat, output logic [N-1:0] res);
        int n;
        logic busy_bad;
        in0 = a;
        in1 = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2 * BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < BOUND + 4) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) fail_now("result_timeout");
        check("busy_in_ready", {31'd0, busy_bad}, 32'd0);
        res = out0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [N-1:0] res;
        int n;

        vecs[0]  = '{8'd48,  8'd18,  8'd6};
        vecs[1]  = '{8'd0,   8'd7,   8'd7};
        vecs[2]  = '{8'd0,   8'd0,   8'd0};
        vecs[3]  = '{8'd7,   8'd0,   8'd7};
        vecs[4]  = '{8'd128, 8'd64,  8'd64};
        vecs[5]  = '{8'd255, 8'd255, 8'd255};
        vecs[6]  = '{8'd255, 8'd1,   8'd1};
        vecs[7]  = '{8'd1,   8'd1,   8'd1};
        vecs[8]  = '{8'd96,  8'd72,  8'd24};
        vecs[9]  = '{8'd17,  8'd13,  8'd1};
        vecs[10] = '{8'd254, 8'd127, 8'd127};
        vecs[11] = '{8'd128, 8'd128, 8'd128};
        for (int i = 12; i < 20; i++) begin
            vecs[i].a   = N'($urandom_range(255, 0));
            vecs[i].b   = N'($urandom_range(255, 0));
            vecs[i].exp = gcd_ref(vecs[i].a, vecs[i].b);
        end

        // Reset state, with in_valid high to show in_ready is held low.
        nrst = 1'b0;
        in_valid = 1'b1;
        in0 = 8'd5;
        in1 = 8'd3;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out0", {24'd0, out0}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Table of calls with out_ready held high.
        for (int i = 0; i < 20; i++) begin
            run_call(vecs[i].a, vecs[i].b, lat, res);
            check("vec_out0", {24'd0, res}, {24'd0, vecs[i].exp});
            check("vec_lat_bound", {31'd0, (lat <= BOUND)}, 32'd1);
            if (vecs[i].a == '0 || vecs[i].b == '0) begin
                check("zero_lat", lat, 32'd1);
            end
`ifdef GCD_BINARY_STEPCOUNT_EN
            check("vec_steps", {16'd0, steps}, lat - 1);
`endif
            @(posedge clk);
            #1;
        end

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        run_call(8'd12, 8'd8, lat, res);
        check("bp_out0", {24'd0, res}, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_out0", {24'd0, out0}, 32'd4);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_after_valid", {31'd0, out_valid}, 32'd0);
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Back-to-back: second call taken on the first result's handshake edge.
        @(posedge clk);
        #1;
        in0 = 8'd12;
        in1 = 8'd8;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2 * BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("b2b_accept_timeout");
        @(posedge clk);
        #1;
        in0 = 8'd9;
        in1 = 8'd6;
        n = 0;
        while (!out_valid && n < BOUND + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_now("b2b_first_timeout");
        check("b2b_first_out0", {24'd0, out0}, 32'd4);
        check("b2b_overlap_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_busy_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_busy_in_ready", {31'd0, in_ready}, 32'd0);
        check("b2b_sb_pending", sb_q.size(), 32'd1);
        n = 0;
        while (!out_valid && n < BOUND + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_now("b2b_second_timeout");
        check("b2b_second_out0", {24'd0, out0}, 32'd3);
        @(posedge clk);
        #1;
        check("b2b_sb_empty", sb_q.size(), 32'd0);

        // Asynchronous reset while in ODD during (200,150).
        @(posedge clk);
        #1;
        in0 = 8'd200;
        in1 = 8'd150;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2 * BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("rst_mid_accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_out_out0_prev", {24'd0, out0}, 32'd3);
        nrst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out0", {24'd0, out0}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        run_call(8'd200, 8'd150, lat, res);
        check("post_rst_out0", {24'd0, res}, 32'd50);
`ifdef GCD_BINARY_STEPCOUNT_EN
        check("post_rst_steps", {16'd0, steps}, lat - 1);
`endif
        @(posedge clk);
        #1;
        check("final_sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_binary_sync.md
Name: gcd_binary_sync

Overview:
- Callee-side implementation of the codebase's synchronous valid/ready call protocol. It is the responder to an initiator that drives in_valid and operands and consumes out0.
- Computes gcd(in0, in1) with a multi-cycle binary (Stein) algorithm, one datapath step per clock.
- Drop-in alternative core for anything instantiated through `inst_sync` with two `intT` inputs and one `intT` output.
- Intended for the switch/LED board benches and for composition inside generated pipelines.

Parameters:
- N, 8, operand/result width in bits; matches `intN.
- KW, $clog2(N)+1, width of the common-power-of-two counter k.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  caller offers operands.
- in_ready  out  1  block can accept operands this cycle.
- in0  in  N  operand a, unsigned.
- in1  in  N  operand b, unsigned.
- out_valid  out  1  out0 holds a finished result.
- out_ready  in  1  caller accepts the result.
- out0  out  N  gcd result, unsigned.

Behaviour:
- Clock and reset: one clock (clk); reset nrst is asynchronous and active-low.
- Reset values: state=IDLE; a=b=0; k=0; out0=0; out_valid=0. in_ready is forced 0 while nrst=0.
- FSM states: IDLE, SCALE, ODD, DONE.
- in_ready is combinational: 1 in IDLE, or in DONE while out_ready=1 (back-to-back calls). 0 in SCALE and ODD.
- Accept: a transfer occurs on an edge where in_valid & in_ready. Then a<=in0, b<=in1, k<=0.
  - If in0==0 or in1==0: out0<=in0|in1 and go to DONE, so gcd(0,0)=0.
  - Otherwise go to SCALE.
- SCALE (one step per cycle):
  - a and b both even: a>>=1, b>>=1, k+=1.
  - Else go to ODD, with no operand change that cycle.
- ODD (priority order, one action per cycle):
  - a even: a>>=1.
  - Else b even: b>>=1.
  - Else a==b: out0<=a<<k, then DONE.
  - Else a>b: a<=a-b.
  - Else b<=b-a.
- Width rules: all arithmetic is unsigned N bits. Subtraction is always larger minus smaller, so it never wraps. a<<k never exceeds min(in0,in1), so it always fits N bits. k never exceeds N-1.
- DONE: out_valid=1 and out0 is held stable until out_ready=1.
  - On the edge with out_ready=1: if in_valid=1, the new operands are accepted per the accept rules above.
  - Otherwise go to IDLE with out_valid<=0.
- Latency: result is visible the cycle after the accept edge when an operand is zero. In all cases it is ≤ 4N+2 cycles.
- In_valid while busy is ignored. The caller must hold its operands until in_ready.
- nrst asserted mid-computation: immediate return to reset values; the pending result is discarded.
- out_valid is never asserted without a preceding accepted call.

Optional Feature:
- Macro GCD_BINARY_STEPCOUNT_EN.
- Defined:
  - Adds output port steps (width 16).
  - steps counts the clock cycles from the accept edge to the DONE entry, saturating at 16'hFFFF.
  - steps is valid and held with out_valid; reset value 0.
- Undefined: the port and the counter are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared header (alongside primitives.v):
  - state encodings IDLE=2'd0, SCALE=2'd1, ODD=2'd2, DONE=2'd3.
  - `intT width macro use.
  - the 4N+2 latency-bound constant for benches.
- Sub-module gcd_binary_step:
  - purely combinational.
  - inputs a, b, k, state.
  - outputs next a, b, k, a done flag and the result.
  - lets the FSM wrapper stay small and the step logic be unit-tested exhaustively at N=4.

Test Plan:
- in0=48, in1=18, out_ready=1 → out_valid within 34 cycles with out0=6; in_ready=0 until DONE.
- in0=0,in1=7 → out0=7. in0=0,in1=0 → out0=0. In both cases out_valid is high the cycle after the accept edge.
- in0=128, in1=64 → out0=64. in0=255, in1=255 → out0=255. in0=255, in1=1 → out0=1 within the 4N+2 bound.
- out_ready held low 5 cycles after DONE for (12,8) → out0=4 stable and out_valid=1 throughout; in_ready=0; release → one transfer.
- Back-to-back: (12,8) then (9,6) offered with out_ready=1 and in_valid held → second call accepted on the first result's handshake edge; results 4 then 3, no idle cycle.
- nrst pulsed low in ODD during (200,150) → out_valid=0 and out0=0 immediately. A following call (200,150) → 50. With GCD_BINARY_STEPCOUNT_EN defined, steps matches the bench's cycle count.
